dp_pass_sequencer: RTL

//  Sequences one MAX_FEATURES-wide signed dot product through NUM_MULTS shared multipliers.

---
 rtl/dp_pass_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dp_pass_sequencer.sv
// dp_pass_sequencer
//   Computes one MAX_FEATURES-wide signed dot product by time-sharing NUM_MULTS
//   multipliers over PASSES = MAX_FEATURES/NUM_MULTS passes. Each pass sums one
//   NUM_MULTS-element slice into a pipelined partial (prod_q), which is folded into the
//   ACC_W accumulator on the following edge. Only one vector is in flight at a time.
//
// Build option:
//   DP_SEQ_SAT_EN  defined   -> result clamped to signed 32-bit, sat flags the clamp
//                  undefined -> result = acc[31:0] (wraps), sat tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   features/weights valid
//   in_ready   out  high in IDLE only
//   features   in   16*MAX_FEATURES, element i at [16*i+15:16*i], signed
//   weights    in   16*MAX_FEATURES, element i at [16*i+15:16*i], signed
//   out_valid  out  high in DONE
//   out_ready  in   downstream accepts result
//   result     out  32-bit signed dot product
//   sat        out  result was clamped
//   busy       out  state != IDLE
//   pass_idx   out  slice currently being multiplied
module dp_pass_sequencer #(
  parameter int unsigned MAX_FEATURES = 8,
  parameter int unsigned NUM_MULTS    = 4,
  parameter int unsigned ACC_W        = 40,
  localparam int unsigned PASSES      = MAX_FEATURES / NUM_MULTS,
  localparam int unsigned PASS_W      = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [16*MAX_FEATURES-1:0] features,
  input  logic [16*MAX_FEATURES-1:0] weights,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               result,
  output logic                      sat,
  output logic                      busy,
  output logic [PASS_W-1:0]         pass_idx
);

  // Elaboration-time parameter checks.
  if (MAX_FEATURES % NUM_MULTS != 0) begin : g_bad_split
    $error("MAX_FEATURES must be a multiple of NUM_MULTS");
  end
  if (ACC_W < 32 + $clog2(MAX_FEATURES)) begin : g_bad_acc
    $error("ACC_W too small for MAX_FEATURES products");
  end

  localparam logic [PASS_W-1:0] LastPass = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {StIdle, StMult, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [16*MAX_FEATURES-1:0] feat_q, wt_q;
  logic signed [ACC_W-1:0]    acc_q, prod_q;
  logic [PASS_W-1:0]          pass_q;
  logic [31:0]                result_q;
  logic                       sat_q;

  logic signed [ACC_W-1:0]    slice_sum;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [31:0]         mult_p;
  int unsigned                elem;
  logic [31:0]                res_d;
  logic                       sat_d;

  // Sum of the NUM_MULTS signed products for the current slice.
  always_comb begin
    slice_sum = '0;
    mult_p    = '0;
    elem      = 0;
    for (int unsigned m = 0; m < NUM_MULTS; m++) begin
      elem      = NUM_MULTS * 32'(pass_q) + m;
      mult_p    = $signed(feat_q[16*elem +: 16]) * $signed(wt_q[16*elem +: 16]);
      slice_sum = slice_sum + {{(ACC_W-32){mult_p[31]}}, mult_p};
    end
  end

  assign acc_sum = acc_q + prod_q;

`ifdef DP_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] MaxRes = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] MinRes = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

  always_comb begin
    res_d = acc_sum[31:0];
    sat_d = 1'b0;
    if (acc_sum > MaxRes) begin
      res_d = 32'h7FFF_FFFF;
      sat_d = 1'b1;
    end else if (acc_sum < MinRes) begin
      res_d = 32'h8000_0000;
      sat_d = 1'b1;
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_sum[ACC_W-1:32];
  assign res_d         = acc_sum[31:0];
  assign sat_d         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMult;
      StMult:  if (pass_q == LastPass) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = result_q;
    pass_idx  = pass_q;
`ifdef DP_SEQ_SAT_EN
    sat       = sat_q;
`else
    sat       = 1'b0;
`endif
  end

`ifndef DP_SEQ_SAT_EN
  logic unused_sat_q;
  assign unused_sat_q = sat_q;
`endif

  // Datapath. prod_q is cleared on accept so the first MULT edge adds zero to acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q   <= '0;
      wt_q     <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      pass_q   <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            feat_q <= features;
            wt_q   <= weights;
            acc_q  <= '0;
            prod_q <= '0;
            pass_q <= '0;
          end
        end
        StMult: begin
          prod_q <= slice_sum;
          acc_q  <= acc_sum;
          pass_q <= (pass_q == LastPass) ? '0 : pass_q + 1'b1;
        end
        StDrain: begin
          acc_q    <= acc_sum;
          result_q <= res_d;
          sat_q    <= sat_d;
        end
        default: ;
      endcase
    end
  end

endmodule
